// File: rtl/nios_core_i2c_pkg.sv
// Shared types and constants for the Avalon-MM I2C master used on the codec configuration path.
package nios_core_i2c_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned TX_W   = 24;

    localparam logic [DIV_W-1:0] DIV_MIN = 16'd4;

    localparam logic [1:0] ADDR_TX     = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_DIV    = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_NACK_BIT = 1;
    localparam int unsigned STAT_DONE_BIT = 2;
    localparam int unsigned STAT_DROP_BIT = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_e;

    typedef struct packed {
        logic [7:0] dev_addr;
        logic [7:0] reg_addr;
        logic [7:0] reg_data;
    } tx_word_t;

endpackage

// File: rtl/nios_core_i2c_tick.sv
// Quarter-bit divider: reloads DIV-1, counts down, ticks at zero; held while idle, frozen on stretch.
module nios_core_i2c_tick
    import nios_core_i2c_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_hold,
    input  logic             i_freeze,
    output logic             o_tick_c
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick_c = !i_hold && !i_freeze && (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_hold || o_tick_c) begin
            r_cnt <= i_div - DIV_W'(1);
        end else if (!i_freeze) begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/nios_core_i2c_master.sv
// Avalon-MM I2C master: one TX write sends START, three ACK-checked bytes and STOP on open-drain pins.
// Define NIOS_CORE_I2C_CLK_STRETCH_EN to honour slave clock stretching via scl_in.
module nios_core_i2c_master
    import nios_core_i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV_DEFAULT = 125
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              sda_in,
    input  logic              scl_in
);

    state_e           r_state, w_state_nxt;
    logic [1:0]       r_q, w_q_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [1:0]       r_byte, w_byte_nxt;
    logic [TX_W-1:0]  r_shift, w_shift_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_nack, w_nack_nxt;
    logic             r_done, w_done_nxt;
    logic             r_dropped, w_dropped_nxt;
    logic             r_scl_oe, r_sda_oe;
    logic             w_scl_oe_c, w_sda_oe_c;
    logic [DIV_W-1:0] r_div;
    logic             w_tick, w_freeze;
    logic             w_wr, w_tx_wr, w_ctrl_clr, w_stop_end, w_accept;
    tx_word_t         w_tx;
    logic             w_unused;

    assign w_wr       = chipselect && !write_n;
    assign w_tx_wr    = w_wr && (address == ADDR_TX);
    assign w_ctrl_clr = w_wr && (address == ADDR_CTRL) && writedata[0];
    // A write landing on the final tick of STOP is treated as arriving while idle.
    assign w_stop_end = w_tick && (r_state == S_STOP) && (r_q == 2'd3);
    assign w_accept   = w_tx_wr && (!r_busy || w_stop_end);
    assign w_tx       = tx_word_t'(writedata[TX_W-1:0]);
    assign w_unused   = ^{writedata[DATA_W-1:TX_W], scl_in};

`ifdef NIOS_CORE_I2C_CLK_STRETCH_EN
    assign w_freeze = ((r_state == S_BIT) || (r_state == S_ACK)) && r_q[1] && !r_scl_oe && !scl_in;
`else
    assign w_freeze = 1'b0;
`endif

    nios_core_i2c_tick u_tick (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_div    (r_div),
        .i_hold   (r_state == S_IDLE),
        .i_freeze (w_freeze),
        .o_tick_c (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_q       <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_shift   <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_nack    <= 1'b0;
            r_done    <= 1'b0;
            r_dropped <= 1'b0;
            r_scl_oe  <= 1'b0;
            r_sda_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_bit     <= w_bit_nxt;
            r_byte    <= w_byte_nxt;
            r_shift   <= w_shift_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_nack    <= w_nack_nxt;
            r_done    <= w_done_nxt;
            r_dropped <= w_dropped_nxt;
            r_scl_oe  <= w_scl_oe_c;
            r_sda_oe  <= w_sda_oe_c;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_bit_nxt     = r_bit;
        w_byte_nxt    = r_byte;
        w_shift_nxt   = r_shift;
        w_ack_nxt     = r_ack;
        w_busy_nxt    = r_busy;
        w_nack_nxt    = r_nack;
        w_done_nxt    = r_done;
        w_dropped_nxt = r_dropped;
        if (w_tick) begin
            w_q_nxt = r_q + 2'd1;
            case (r_state)
                S_START: begin
                    if (r_q == 2'd3) begin
                        w_state_nxt = S_BIT;
                        w_bit_nxt   = '0;
                    end
                end
                S_BIT: begin
                    if (r_q == 2'd3) begin
                        w_shift_nxt = {r_shift[TX_W-2:0], 1'b0};
                        w_bit_nxt   = r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            w_state_nxt = S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    if (r_q == 2'd2) begin
                        w_ack_nxt = sda_in;
                    end
                    if (r_q == 2'd3) begin
                        if (r_ack) begin
                            w_nack_nxt  = 1'b1;
                            w_state_nxt = S_STOP;
                        end else if (r_byte == 2'd2) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_byte_nxt  = r_byte + 2'd1;
                            w_state_nxt = S_BIT;
                        end
                    end
                end
                S_STOP: begin
                    if (r_q == 2'd3) begin
                        w_state_nxt = S_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_q_nxt = '0;
            endcase
        end
        if (w_ctrl_clr) begin
            w_nack_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_dropped_nxt = 1'b0;
        end
        if (w_accept) begin
            w_state_nxt = S_START;
            w_q_nxt     = '0;
            w_bit_nxt   = '0;
            w_byte_nxt  = '0;
            w_shift_nxt = w_tx;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_nack_nxt  = 1'b0;
        end else if (w_tx_wr) begin
            w_dropped_nxt = 1'b1;
        end
    end

    // Line levels for the current quarter; registered so reset releases the pins at once.
    always_comb begin
        w_scl_oe_c = 1'b0;
        w_sda_oe_c = 1'b0;
        case (r_state)
            S_START: begin
                w_sda_oe_c = (r_q != 2'd0);
                w_scl_oe_c = (r_q == 2'd3);
            end
            S_BIT: begin
                w_sda_oe_c = !r_shift[TX_W-1];
                w_scl_oe_c = !r_q[1];
            end
            S_ACK: begin
                w_scl_oe_c = !r_q[1];
            end
            S_STOP: begin
                w_sda_oe_c = (r_q != 2'd3);
                w_scl_oe_c = (r_q == 2'd0);
            end
            default: ;
        endcase
    end

    assign scl_oe = r_scl_oe;
    assign sda_oe = r_sda_oe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= DIV_W'(CLK_DIV_DEFAULT);
        end else if (w_wr && (address == ADDR_DIV)) begin
            r_div <= (writedata[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : writedata[DIV_W-1:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_STATUS: begin
                readdata[STAT_BUSY_BIT] = r_busy;
                readdata[STAT_NACK_BIT] = r_nack;
                readdata[STAT_DONE_BIT] = r_done;
                readdata[STAT_DROP_BIT] = r_dropped;
            end
            ADDR_DIV: readdata[DIV_W-1:0] = r_div;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nios_core_i2c_master.sv
// Bench for nios_core_i2c_master: bus-level I2C slave/decoder plus transfer-level expectations.
module tb_nios_core_i2c_master;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        scl_oe;
    logic        sda_oe;
    logic        sda_in;
    logic        scl_in;

    logic        r_pull;
    logic        r_str;
    logic        r_str_done;
    int          str_cnt;
    logic        str_req;
    logic [3:0]  ack_en;

    logic        m_pscl, m_psda, m_inack;
    int          m_bitcnt;
    logic [7:0]  m_sh;
    logic [1:0]  m_byte_n;
    int          m_stops = 0;
    logic [7:0]  got[$];

    int n_cmp = 0;
    int n_mis = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Open-drain wired-AND pins.
    assign sda_in = !(sda_oe || r_pull);
    assign scl_in = !(scl_oe || r_str);

    nios_core_i2c_master #(.CLK_DIV_DEFAULT(125)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in),
        .scl_in     (scl_in)
    );

    // Slave: detects START/STOP, samples bits on SCL rise, ACKs per ack_en, optional stretch.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_pscl     <= 1'b1;
            m_psda     <= 1'b1;
            m_inack    <= 1'b0;
            m_bitcnt   <= 0;
            m_sh       <= '0;
            m_byte_n   <= '0;
            r_pull     <= 1'b0;
            r_str      <= 1'b0;
            r_str_done <= 1'b0;
            str_cnt    <= 0;
        end else begin
            m_pscl <= scl_in;
            m_psda <= sda_in;
            if (m_pscl && scl_in && m_psda && !sda_in) begin
                m_bitcnt <= 0;
                m_inack  <= 1'b0;
                m_byte_n <= '0;
            end else if (m_pscl && scl_in && !m_psda && sda_in) begin
                m_stops <= m_stops + 1;
            end else if (!m_pscl && scl_in) begin
                if (m_bitcnt < 8) begin
                    m_sh     <= {m_sh[6:0], sda_in};
                    m_bitcnt <= m_bitcnt + 1;
                    if (m_bitcnt == 7) got.push_back({m_sh[6:0], sda_in});
                end
            end else if (m_pscl && !scl_in) begin
                if (m_bitcnt == 8 && !m_inack) begin
                    r_pull  <= ack_en[m_byte_n];
                    m_inack <= 1'b1;
                end else if (m_inack) begin
                    r_pull   <= 1'b0;
                    m_inack  <= 1'b0;
                    m_bitcnt <= 0;
                    m_byte_n <= m_byte_n + 2'd1;
                end
            end
            if (str_req && !r_str_done && m_byte_n == 2'd0 && m_bitcnt == 3 && !scl_in && !m_inack) begin
                r_str      <= 1'b1;
                r_str_done <= 1'b1;
                str_cnt    <= 0;
            end else if (r_str && !scl_oe) begin
                if (str_cnt == 50) r_str <= 1'b0;
                str_cnt <= str_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic av_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
    endtask

    task automatic av_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // One transfer; expectations come from the ACK pattern and quarter arithmetic.
    task automatic run_xfer(input string tag, input logic [23:0] word, input int div,
                            input logic [3:0] acks, input int inj_at, input int extra);
        int nb, eff, count, q0, stops0;
        logic nk, fin;
        logic [31:0] st;
        nb = 3; nk = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (!acks[i]) begin nb = i + 1; nk = 1'b1; end
        end
        eff = (div < 4) ? 4 : div;
        ack_en = acks;
        av_write(2'd2, 32'(div));
        q0 = got.size();
        stops0 = m_stops;
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = {8'($urandom), word};
        count = 0; fin = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
            #1;
            if (!readdata[0] || count >= 5000) begin
                fin = 1'b1;
            end else begin
                count++;
                if (count == inj_at) begin
                    chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = $urandom;
                end
            end
        end
        chk({tag, "_busy_clks"}, count, (8 + 36 * nb) * eff + extra);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nbytes"}, got.size() - q0, nb);
        for (int i = 0; i < nb; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(got[q0 + i]), 32'(8'(word >> (16 - 8 * i))));
        end
        chk({tag, "_stop"}, m_stops - stops0, 1);
        av_read(2'd1, st);
        chk({tag, "_status"}, st, {28'b0, (inj_at > 0), 1'b1, nk, 1'b0});
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        found;
        logic [3:0]  acks;
        int          div;
        reset_n = 1'b0; address = 2'd1; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        str_req = 1'b0; ack_en = 4'hF;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_scl_oe", 32'(scl_oe), 0);
        chk("rst_sda_oe", 32'(sda_oe), 0);
        av_read(2'd1, rd); chk("rst_status", rd, 0);
        av_read(2'd2, rd); chk("rst_div", rd, 125);
        av_read(2'd3, rd); chk("rst_ctrl", rd, 0);

        run_xfer("ack_all", 24'h341E00, 4, 4'hF, 0, 0);
        run_xfer("nack_b0", 24'($urandom), 4, 4'b1110, 0, 0);
        run_xfer("dropped", 24'($urandom), 4, 4'hF, 20, 0);
        av_write(2'd3, 32'h1);
        av_read(2'd1, rd); chk("ctrl_clear", rd, 0);

        av_write(2'd2, 32'd1);          av_read(2'd2, rd); chk("div_1", rd, 4);
        av_write(2'd2, 32'd3);          av_read(2'd2, rd); chk("div_3", rd, 4);
        av_write(2'd2, 32'hFFFF_0005);  av_read(2'd2, rd); chk("div_5", rd, 5);

        av_write(2'd2, 32'd4);
        @(negedge clk);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'h00A5C3F0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 2'd1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(posedge clk); #1;
            if (k >= 20 && scl_oe) found = 1'b1;
        end
        chk("midbit_reached", 32'(found), 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_scl_oe", 32'(scl_oe), 0);
        chk("midrst_sda_oe", 32'(sda_oe), 0);
        av_read(2'd1, rd); chk("midrst_status", rd, 0);
        av_read(2'd2, rd); chk("midrst_div", rd, 125);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int n = 0; n < 6; n++) begin
            div  = $urandom_range(1, 8);
            acks = ($urandom_range(0, 2) == 0) ? {1'b1, 3'($urandom)} : 4'hF;
            run_xfer($sformatf("rnd%0d", n), 24'($urandom), div, acks, 0, 0);
        end

`ifdef NIOS_CORE_I2C_CLK_STRETCH_EN
        str_req = 1'b1;
        run_xfer("stretch", 24'h5A3C96, 4, 4'hF, 0, 50);
        str_req = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
